dmem_responder: RTL and testbench

Data-memory responder serving the core's data-memory request port. Accepts one load/store request at a time via valid/ready, executes it against an internal word-organised array with byte-lane masking, and returns a registered response. Load results are sign- or zero-extended. Provides a busy flag the control path can fold into its cache-miss stall.

---
 rtl/dmem_responder.sv | 190 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with byte-lane
// masked stores, sign/zero-extended loads and a registered response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_fcn,
  input  logic [2:0]  req_typ,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          accept_s;
  logic [AW+1:0] addr_r;
  logic [31:0]   data_r;
  logic          fcn_r;
  logic [2:0]    typ_r;
  logic [31:0]   resp_data_r;
  logic          resp_err_r;
  logic [31:0]   mem_r [DEPTH_WORDS];

  logic          is_byte_s, is_half_s, is_signed_s, misaligned_s, wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s, rword_s, lane_s, rdata_s;
  logic [AW-1:0] idx_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^req_addr[31:AW+2];

  // Lane enables for a naturally aligned access of the given size.
  function automatic logic [3:0] lane_mask(input logic byte_acc, input logic half_acc,
                                           input logic [1:0] offs);
    logic [3:0] m;
    if (byte_acc) begin
      m = 4'b0001 << offs;
    end else if (half_acc) begin
      m = offs[1] ? 4'b1100 : 4'b0011;
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

  // Extend the low byte or half of a right-aligned lane value.
  function automatic logic [31:0] extend(input logic [31:0] lane, input logic byte_acc,
                                         input logic half_acc, input logic sgn);
    logic [31:0] r;
    if (byte_acc) begin
      r = {{24{sgn & lane[7]}}, lane[7:0]};
    end else if (half_acc) begin
      r = {{16{sgn & lane[15]}}, lane[15:0]};
    end else begin
      r = lane;
    end
    return r;
  endfunction

  // Next-state and handshake decode.
  always_comb begin
    state_s   = state_r;
    req_ready = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = ACCESS;
        end else begin
          state_s  = IDLE;
        end
      end
      ACCESS: begin
        state_s = RESPOND;
      end
      RESPOND: begin
        if (resp_ready) begin
          req_ready = 1'b1;
          if (req_valid) begin
            accept_s = 1'b1;
            state_s  = ACCESS;
          end else begin
            state_s  = IDLE;
          end
        end else begin
          state_s = RESPOND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Access decode: type, alignment, lane enables, read extraction.
  always_comb begin
    is_byte_s   = 1'b0;
    is_half_s   = 1'b0;
    is_signed_s = 1'b0;
    case (typ_r)
      3'd1:    begin is_byte_s = 1'b1; is_signed_s = 1'b1; end
      3'd2:    begin is_half_s = 1'b1; is_signed_s = 1'b1; end
      3'd4:    begin is_byte_s = 1'b1; end
      3'd5:    begin is_half_s = 1'b1; end
      default: begin is_byte_s = 1'b0; end
    endcase
    if (is_byte_s) begin
      misaligned_s = 1'b0;
    end else if (is_half_s) begin
      misaligned_s = addr_r[0];
    end else begin
      misaligned_s = (addr_r[1:0] != 2'b00);
    end
    idx_s   = addr_r[AW+1:2];
    be_s    = lane_mask(is_byte_s, is_half_s, addr_r[1:0]);
    wdata_s = is_byte_s ? {4{data_r[7:0]}} : (is_half_s ? {2{data_r[15:0]}} : data_r);
    rword_s = mem_r[idx_s];
    lane_s  = rword_s >> {addr_r[1:0], 3'b000};
    rdata_s = extend(lane_s, is_byte_s, is_half_s, is_signed_s);
    wr_en_s = (state_r == ACCESS) && fcn_r && !misaligned_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, loaded on every accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      data_r <= 32'd0;
      fcn_r  <= 1'b0;
      typ_r  <= 3'd0;
    end else if (accept_s) begin
      addr_r <= req_addr[AW+1:0];
      data_r <= req_data;
      fcn_r  <= req_fcn;
      typ_r  <= req_typ;
    end
  end

  // Response registers, captured at the end of ACCESS and held through RESPOND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data_r <= 32'd0;
      resp_err_r  <= 1'b0;
    end else if (state_r == ACCESS) begin
      resp_data_r <= (fcn_r || misaligned_s) ? 32'd0 : rdata_s;
      resp_err_r  <= misaligned_s;
    end
  end

  // Word array with per-lane write enables; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign resp_valid = (state_r == RESPOND);
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic checked against a byte-addressed reference memory.
module tb_dmem_responder;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic        req_fcn = 1'b0;
  logic [2:0]  req_typ = 3'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_mem [NBYTES];

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .req_fcn(req_fcn), .req_typ(req_typ),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: little-endian byte memory, size/sign from the type code.
  function automatic void ref_access(input logic fcn, input logic [2:0] typ,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic err);
    int size;
    bit sgn;
    int base;
    logic [31:0] v;
    case (typ)
      3'd1:    begin size = 1; sgn = 1'b1; end
      3'd2:    begin size = 2; sgn = 1'b1; end
      3'd4:    begin size = 1; sgn = 1'b0; end
      3'd5:    begin size = 2; sgn = 1'b0; end
      default: begin size = 4; sgn = 1'b0; end
    endcase
    base = int'(addr % NBYTES);
    err  = (addr % size) != 0;
    rd   = 32'd0;
    if (!err) begin
      if (fcn) begin
        for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[base + i];
        if (sgn && v[8*size - 1])
          for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endfunction

  task automatic drive(input logic fcn, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_fcn   = fcn;
    req_typ   = typ;
    req_addr  = addr;
    req_data  = wd;
  endtask

  // One transaction from IDLE, optional response stall, back to IDLE.
  task automatic xact(input string tag, input logic fcn, input logic [2:0] typ,
                      input logic [31:0] addr, input logic [31:0] wd, input int stall);
    logic [31:0] exp_d;
    logic        exp_e;
    ref_access(fcn, typ, addr, wd, exp_d, exp_e);
    drive(fcn, typ, addr, wd);
    #1;
    check_eq({tag, ".rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq({tag, ".lat"}, 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, ".vld"}, 32'(resp_valid), 32'd1);
    check_eq({tag, ".data"}, resp_data, exp_d);
    check_eq({tag, ".err"}, 32'(resp_err), 32'(exp_e));
    if (stall > 0) begin
      resp_ready = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      check_eq({tag, ".hold"}, resp_data, exp_d);
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.vld", 32'(resp_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.rdy", 32'(req_ready), 32'd1);
    check_eq("rst.data", resp_data, 32'd0);
    check_eq("rst.err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 64; w++) xact("init", 1'b1, 3'd3, 32'(w * 4), $urandom, 0);

    xact("w_st", 1'b1, 3'd3, 32'h10, 32'hDEADBEEF, 0);
    xact("w_ld", 1'b0, 3'd3, 32'h10, 32'h0, 0);
    xact("z_st", 1'b1, 3'd3, 32'h20, 32'h0, 0);
    xact("b_st", 1'b1, 3'd1, 32'h23, 32'h80, 0);
    xact("b_w", 1'b0, 3'd3, 32'h20, 32'h0, 0);
    xact("b_ld", 1'b0, 3'd1, 32'h23, 32'h0, 0);
    xact("bu_ld", 1'b0, 3'd4, 32'h23, 32'h0, 0);
    xact("h_st", 1'b1, 3'd2, 32'h32, 32'h1234ABCD, 0);
    xact("h_w", 1'b0, 3'd3, 32'h30, 32'h0, 0);
    xact("hu_ld", 1'b0, 3'd5, 32'h32, 32'h0, 0);
    xact("h_ld", 1'b0, 3'd2, 32'h32, 32'h0, 0);
    xact("mis_st", 1'b1, 3'd3, 32'h41, 32'hCAFEF00D, 0);
    xact("mis_chk", 1'b0, 3'd3, 32'h40, 32'h0, 0);
    xact("mis_h", 1'b0, 3'd2, 32'h45, 32'h0, 0);
    xact("wrap_st", 1'b1, 3'd3, 32'h1004, 32'h5A5AA5A5, 0);
    xact("wrap_ld", 1'b0, 3'd3, 32'h0004, 32'h0, 0);

    // Backpressure: response held for 5 cycles, then back-to-back accept.
    ref_access(1'b0, 3'd3, 32'h10, 32'h0, exp_d, exp_e);
    resp_ready = 1'b0;
    drive(1'b0, 3'd3, 32'h10, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp.vld", 32'(resp_valid), 32'd1);
      check_eq("bp.data", resp_data, exp_d);
      check_eq("bp.err", 32'(resp_err), 32'd0);
      check_eq("bp.rdy", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    ref_access(1'b0, 3'd1, 32'h23, 32'h0, exp_d, exp_e);
    drive(1'b0, 3'd1, 32'h23, 32'h0);
    resp_ready = 1'b1;
    #1;
    check_eq("b2b.rdy", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("b2b.lat", 32'(resp_valid), 32'd0);
    check_eq("b2b.busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_eq("b2b.vld", 32'(resp_valid), 32'd1);
    check_eq("b2b.data", resp_data, exp_d);
    @(posedge clk); #1;

    // Reset asserted while a store sits in ACCESS (target word never read).
    drive(1'b1, 3'd3, 32'h1F0, 32'h11111111);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("ra.busy0", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("ra.vld", 32'(resp_valid), 32'd0);
    check_eq("ra.busy", 32'(busy), 32'd0);
    check_eq("ra.rdy", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check_eq("ra.vld2", 32'(resp_valid), 32'd0);
    check_eq("ra.data", resp_data, 32'd0);
    check_eq("ra.err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      xact("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
           int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
